// File: rtl/gpu_pkg.sv
// Shared definitions for the GPU graphics DMA channel: FSM encoding and address widths.
package gpu_pkg;

    localparam int SDR_AW = 23;
    localparam int DMA_AW = 14;
    localparam int CNT_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } dma_state_e;

endpackage : gpu_pkg

// File: rtl/gpu_dma_reader.sv
// Per-layer DMA responder: turns slot-strobed fetch requests into fixed-length
// SDRAM read bursts and returns the words one per cycle through a registered port.
module gpu_dma_reader
    import gpu_pkg::*;
#(
    parameter logic [SDR_AW-1:0] BASE_ADDR = 23'h000000,
    parameter int                SLOT      = 2,
    parameter int                BURST     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        ram_cyc,
    input  logic [3:0]        ram_ph,
    input  logic [15:2]       dma_addr,
    input  logic              dma_rden,
    output logic              dma_data_vld,
    output logic [15:0]       dma_data,
    output logic              sdr_req,
    output logic [SDR_AW-1:0] sdr_addr,
    input  logic              sdr_ack,
    input  logic              sdr_rvld,
    input  logic [15:0]       sdr_rdata,
    output logic              ovf
);

    dma_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SDR_AW-1:0] addr_q, addr_d;
    logic              vld_q, vld_d;
    logic [15:0]       data_q, data_d;
    logic              ovf_q, ovf_d;
    logic              stb;
    logic              req_hit;

    assign stb     = ram_cyc[SLOT] & ram_ph[0];
    assign req_hit = stb & dma_rden;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        vld_d   = 1'b0;
        data_d  = data_q;
        ovf_d   = ovf_q;

        // A request arriving while a burst is outstanding is dropped and flagged.
        if (req_hit && (state_q != ST_IDLE)) begin
            ovf_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (req_hit) begin
                    addr_d  = BASE_ADDR + SDR_AW'({dma_addr, 1'b0});
                    cnt_d   = CNT_W'(BURST);
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                // A read word coincident with the ack belongs to nobody; it is not counted.
                if (sdr_ack) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (sdr_rvld) begin
                    vld_d  = 1'b1;
                    data_d = sdr_rdata;
                    cnt_d  = cnt_q - CNT_W'(1);
                    if (cnt_q <= CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            vld_q   <= 1'b0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            vld_q   <= vld_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
        end
    end

    // Request follows the state directly so the ack cycle drops it without a lag.
    assign sdr_req      = (state_q == ST_CMD);
    assign sdr_addr     = addr_q;
    assign dma_data_vld = vld_q;
    assign dma_data     = data_q;
    assign ovf          = ovf_q;

endmodule : gpu_dma_reader

// File: tb/tb_gpu_dma_reader.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized
// traffic, all compared every cycle against a transaction-level model of the channel.
module tb_gpu_dma_reader;

    localparam logic [22:0] BASE_A = 23'h010000;
    localparam logic [22:0] BASE_B = 23'h7FFFFE;
    localparam int          NBURST = 2;

    logic        clk;
    logic        rst_n;
    logic [3:0]  ram_cyc;
    logic [3:0]  ram_ph;
    logic [15:2] dma_addr;
    logic        dma_rden;
    logic        sdr_ack;
    logic        sdr_rvld;
    logic [15:0] sdr_rdata;

    logic        vld_a, vld_b, req_a, req_b, ovf_a, ovf_b;
    logic [15:0] data_a, data_b;
    logic [22:0] addr_a, addr_b;

    int checks = 0;
    int passes = 0;

    gpu_dma_reader #(.BASE_ADDR(BASE_A), .SLOT(2), .BURST(NBURST)) dut_a (
        .clk(clk), .rst_n(rst_n), .ram_cyc(ram_cyc), .ram_ph(ram_ph),
        .dma_addr(dma_addr), .dma_rden(dma_rden),
        .dma_data_vld(vld_a), .dma_data(data_a),
        .sdr_req(req_a), .sdr_addr(addr_a), .sdr_ack(sdr_ack),
        .sdr_rvld(sdr_rvld), .sdr_rdata(sdr_rdata), .ovf(ovf_a)
    );

    gpu_dma_reader #(.BASE_ADDR(BASE_B), .SLOT(2), .BURST(NBURST)) dut_b (
        .clk(clk), .rst_n(rst_n), .ram_cyc(ram_cyc), .ram_ph(ram_ph),
        .dma_addr(dma_addr), .dma_rden(dma_rden),
        .dma_data_vld(vld_b), .dma_data(data_b),
        .sdr_req(req_b), .sdr_addr(addr_b), .sdr_ack(sdr_ack),
        .sdr_rvld(sdr_rvld), .sdr_rdata(sdr_rdata), .ovf(ovf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // The channel holds at most one outstanding transaction: a request is either
    // waiting for its command to be accepted, or waiting for words_left more words.
    bit          m_open;
    bit          m_accepted;
    int          m_words_left;
    logic [22:0] m_addr_a, m_addr_b;
    logic        m_vld;
    logic [15:0] m_data;
    logic        m_ovf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_open = 0; m_accepted = 0; m_words_left = 0;
            m_addr_a = '0; m_addr_b = '0; m_vld = 0; m_data = '0; m_ovf = 0;
        end else begin
            bit was_open, was_accepted, strobe;
            was_open     = m_open;
            was_accepted = m_accepted;
            strobe       = ram_cyc[2] && ram_ph[0] && dma_rden;
            m_vld        = 0;
            if (strobe) begin
                if (was_open) m_ovf = 1;
                else begin
                    m_open       = 1;
                    m_accepted   = 0;
                    m_words_left = NBURST;
                    m_addr_a     = 23'((int'(BASE_A) + 2 * int'(dma_addr)) % (1 << 23));
                    m_addr_b     = 23'((int'(BASE_B) + 2 * int'(dma_addr)) % (1 << 23));
                end
            end
            if (was_open && !was_accepted && sdr_ack) m_accepted = 1;
            if (was_open && was_accepted && sdr_rvld) begin
                m_vld  = 1;
                m_data = sdr_rdata;
                m_words_left--;
                if (m_words_left == 0) begin
                    m_open = 0;
                    m_accepted = 0;
                end
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        chk("req_a",  {31'd0, req_a},  {31'd0, m_open && !m_accepted});
        chk("req_b",  {31'd0, req_b},  {31'd0, m_open && !m_accepted});
        chk("addr_a", {9'd0, addr_a},  {9'd0, m_addr_a});
        chk("addr_b", {9'd0, addr_b},  {9'd0, m_addr_b});
        chk("vld_a",  {31'd0, vld_a},  {31'd0, m_vld});
        chk("vld_b",  {31'd0, vld_b},  {31'd0, m_vld});
        chk("data_a", {16'd0, data_a}, {16'd0, m_data});
        chk("data_b", {16'd0, data_b}, {16'd0, m_data});
        chk("ovf_a",  {31'd0, ovf_a},  {31'd0, m_ovf});
        chk("ovf_b",  {31'd0, ovf_b},  {31'd0, m_ovf});
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        ram_cyc = 4'b0000; ram_ph = 4'b0000; dma_rden = 0;
        sdr_ack = 0; sdr_rvld = 0;
    endtask

    task automatic strobe(input logic [15:2] a);
        ram_cyc = 4'b0100; ram_ph = 4'b0001; dma_rden = 1; dma_addr = a;
        tick();
        quiet();
    endtask

    task automatic word(input logic [15:0] d);
        sdr_rvld = 1; sdr_rdata = d;
        tick();
        sdr_rvld = 0;
    endtask

    task automatic ack();
        sdr_ack = 1;
        tick();
        sdr_ack = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        tick(); tick();
        rst_n = 1;
        tick();
    endtask

    initial begin
        quiet();
        dma_addr = '0; sdr_rdata = '0;
        rst_n = 0;
        #2;
        chk("reset_req",  {31'd0, req_a}, 32'd0);
        chk("reset_ovf",  {31'd0, ovf_a}, 32'd0);
        chk("reset_addr", {9'd0, addr_a}, 32'd0);
        tick(); tick();
        rst_n = 1;
        repeat (8) tick();

        // Request, address, burst return.
        strobe(14'h0123);
        chk("t1_req",    {31'd0, req_a}, 32'd1);
        chk("t1_addr_a", {9'd0, addr_a}, 32'h010246);
        chk("t1_addr_b", {9'd0, addr_b}, 32'h000244);
        tick();
        chk("t1_req_hold", {31'd0, req_a}, 32'd1);
        ack();
        chk("t2_req_drop", {31'd0, req_a}, 32'd0);
        tick();
        word(16'hA5A5);
        chk("t2_vld0",  {31'd0, vld_a}, 32'd1);
        chk("t2_data0", {16'd0, data_a}, 32'h0000A5A5);
        word(16'h5A5A);
        chk("t2_vld1",  {31'd0, vld_a}, 32'd1);
        chk("t2_data1", {16'd0, data_a}, 32'h00005A5A);
        tick();
        chk("t2_vld_end",  {31'd0, vld_a}, 32'd0);
        chk("t2_data_hld", {16'd0, data_a}, 32'h00005A5A);
        chk("t2_ovf",      {31'd0, ovf_a}, 32'd0);

        // Overlapping request while in DATA.
        strobe(14'h0010);
        ack();
        word(16'h1234);
        strobe(14'h0020);
        chk("t3_ovf", {31'd0, ovf_a}, 32'd1);
        chk("t3_req", {31'd0, req_a}, 32'd0);
        word(16'h4321);
        chk("t3_last", {16'd0, data_a}, 32'h00004321);
        for (int i = 0; i < 1000; i++) begin
            sdr_rvld = 1'($urandom_range(0, 1));
            sdr_rdata = 16'($urandom);
            tick();
            if (vld_a !== 1'b0) chk("t4_idle_vld", {31'd0, vld_a}, 32'd0);
        end
        sdr_rvld = 0;
        chk("t3_ovf_sticky", {31'd0, ovf_a}, 32'd1);

        // Ack and rvld coincide in CMD.
        do_reset();
        strobe(14'h0002);
        sdr_ack = 1; sdr_rvld = 1; sdr_rdata = 16'h1111;
        tick();
        quiet();
        chk("t5_no_fwd", {31'd0, vld_a}, 32'd0);
        word(16'h2222);
        chk("t5_w0", {16'd0, data_a}, 32'h00002222);
        chk("t5_v0", {31'd0, vld_a}, 32'd1);
        word(16'h3333);
        chk("t5_w1", {16'd0, data_a}, 32'h00003333);
        strobe(14'h0003);
        chk("t5_idle_again", {31'd0, req_a}, 32'd1);
        chk("t5_ovf", {31'd0, ovf_a}, 32'd0);

        // Reset in the middle of a burst.
        ack();
        word(16'h7777);
        rst_n = 0;
        #1;
        chk("t6_vld",  {31'd0, vld_a}, 32'd0);
        chk("t6_data", {16'd0, data_a}, 32'd0);
        chk("t6_addr", {9'd0, addr_a}, 32'd0);
        chk("t6_req",  {31'd0, req_a}, 32'd0);
        tick();
        rst_n = 1;
        word(16'h8888);
        chk("t6_late", {31'd0, vld_a}, 32'd0);
        strobe(14'h0004);
        chk("t6_req2", {31'd0, req_a}, 32'd1);
        chk("t6_addr2", {9'd0, addr_a}, 32'h010008);
        ack();
        word(16'h9999);
        word(16'hAAAA);
        chk("t6_done", {16'd0, data_a}, 32'h0000AAAA);
        tick();

        // Address wrap.
        strobe(14'h0001);
        chk("t7_wrap_b", {9'd0, addr_b}, 32'h000000);
        chk("t7_addr_a", {9'd0, addr_a}, 32'h010002);
        ack();
        word(16'hBEEF);
        word(16'hCAFE);
        tick();

        // Randomized traffic with occasional mid-cycle resets.
        for (int i = 0; i < 3000; i++) begin
            ram_cyc   = 4'b0001 << $urandom_range(0, 3);
            ram_ph    = 4'b0001 << $urandom_range(0, 3);
            dma_rden  = ($urandom_range(0, 3) == 0);
            dma_addr  = 14'($urandom);
            sdr_ack   = m_open && !m_accepted && ($urandom_range(0, 2) == 0);
            sdr_rvld  = ($urandom_range(0, 1) == 1);
            sdr_rdata = 16'($urandom);
            if ($urandom_range(0, 199) == 0) rst_n = 0;
            else rst_n = 1;
            tick();
        end
        quiet();
        rst_n = 1;
        tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_gpu_dma_reader
